// File: rtl/home_pkg.sv
// Shared types and field layout for the home status transmitter.
package home_pkg;

    localparam int PAYLOAD_W  = 12;
    localparam int HEAT_B     = 0;
    localparam int COOL_B     = 1;
    localparam int BLIND_LSB  = 2;
    localparam int COLOUR_LSB = 4;
    localparam int TEMP_LSB   = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic [PAYLOAD_W-1:0] pack_status(
        input logic       heating,
        input logic       cooling,
        input logic [1:0] blinds,
        input logic [2:0] colour,
        input logic [4:0] temperature
    );
        logic [PAYLOAD_W-1:0] w;
        w                         = '0;
        w[HEAT_B]                 = heating;
        w[COOL_B]                 = cooling;
        w[BLIND_LSB +: 2]         = blinds;
        w[COLOUR_LSB +: 3]        = colour;
        w[TEMP_LSB +: 5]          = temperature;
        return w;
    endfunction

endpackage

// File: rtl/home_status_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1, flags the last cycle.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/home_status_tx.sv
// Serial status frame transmitter to the wall panel, LSB first.
// Optional even-parity bit enabled by HOME_STATUS_TX_PARITY_EN.
module home_status_tx
    import home_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    input  logic [1:0] blinds,
    input  logic [2:0] colour,
    input  logic [4:0] temperature,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_BIT = 4'(PAYLOAD_W - 1);

    tx_state_t            state, state_d;
    logic [PAYLOAD_W-1:0] payload;
    logic [PAYLOAD_W-1:0] shift_q;
    logic [PAYLOAD_W-1:0] last_sent;
    logic [3:0]           bit_cnt;
    logic                 bit_end;
    logic                 trigger;
    logic                 load;

    assign payload = pack_status(heating, cooling, blinds, colour, temperature);
    assign trigger = send_req || (payload != last_sent);
    // The final STOP cycle counts as IDLE so frames can run back to back.
    assign load    = trigger &&
                     ((state == IDLE) || ((state == STOP) && bit_end));

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            last_sent <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                shift_q   <= payload;
                last_sent <= payload;
                bit_cnt   <= '0;
            end else if ((state == DATA) && bit_end) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        tx      = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) state_d = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef HOME_STATUS_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef HOME_STATUS_TX_PARITY_EN
            PARITY: begin
                // last_sent always equals the word in flight
                tx = ^last_sent;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                done = bit_end;
                if (bit_end) state_d = trigger ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_home_status_tx.sv
// Self-checking bench for home_status_tx with a frame-position model.
module tb_home_status_tx;

    localparam int C = 4;
`ifdef HOME_STATUS_TX_PARITY_EN
    localparam int NB = 15;
`else
    localparam int NB = 14;
`endif
    localparam int LEN = NB * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       heating = 1'b0;
    logic       cooling = 1'b0;
    logic [1:0] blinds = 2'd0;
    logic [2:0] colour = 3'd0;
    logic [4:0] temperature = 5'd0;
    logic       send_req = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    home_status_tx #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .heating    (heating),
        .cooling    (cooling),
        .blinds     (blinds),
        .colour     (colour),
        .temperature(temperature),
        .send_req   (send_req),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    // Model: position within the frame (-1 when idle) and the word being sent.
    int          m_pos = -1;
    logic [11:0] m_word = '0;
    logic [11:0] m_last = '0;
    wire  [11:0] cur = {temperature, colour, blinds, cooling, heating};

    always @(posedge clk) begin
        if (rst) begin
            m_pos  <= -1;
            m_last <= '0;
        end else if (m_pos < 0 || m_pos == LEN - 1) begin
            if (send_req || cur != m_last) begin
                m_word <= cur;
                m_last <= cur;
                m_pos  <= 0;
            end else begin
                m_pos <= -1;
            end
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    function automatic logic exp_tx(input int p, input logic [11:0] w);
        int slot;
        if (p < 0) return 1'b1;
        slot = p / C;
        if (slot == 0) return 1'b0;
        if (slot <= 12) return w[slot-1];
        if (NB == 15 && slot == 13) return ^w;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [2:0] e;
            e = {exp_tx(m_pos, m_word), m_pos >= 0, m_pos == LEN - 1};
            checks++;
            if ({tx, busy, done} !== e) begin
                errors++;
                $display("FAIL model t=%0t tx/busy/done=%b expected %b",
                         $time, {tx, busy, done}, e);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    initial begin
        int          bsum;
        int          d0;
        int          first_done;
        bit          found;
        logic [14:0] line;
        logic [14:0] exp_line;

        tick(3);
        cmp_en = 1'b1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;

        // all-zero status: nothing to send
        bsum = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bsum += int'(busy);
            bsum += int'(!tx);
        end
        check("idle_no_frame", bsum, 0);
        check("idle_no_done", done_cnt, 0);

        // payload 12'hAC5
        temperature = 5'd21;
        colour      = 3'b100;
        blinds      = 2'b01;
        heating     = 1'b1;
        line        = '1;
        first_done  = -1;
        for (int j = 1; j <= LEN + 2; j++) begin
            @(negedge clk);
            if (j - 1 < LEN && (j - 1) % C == 1) line[(j-1)/C] = tx;
            if (done === 1'b1 && first_done < 0) first_done = j;
        end
`ifdef HOME_STATUS_TX_PARITY_EN
        exp_line = 15'b1_0_101011000101_0;
`else
        exp_line = 15'b1_1_101011000101_0;
`endif
        check("frame_bits", int'(line), int'(exp_line));
        check("done_cycle", first_done, LEN);
        tick(5);

        // forced resend of unchanged status
        d0 = done_cnt;
        pulse_req();
        tick(LEN + 10);
        check("resend_one_frame", done_cnt - d0, 1);

        // send_req mid-frame is ignored
        d0 = done_cnt;
        pulse_req();
        tick(19);
        pulse_req();
        tick(LEN + 10);
        check("midframe_req_ignored", done_cnt - d0, 1);

        // heating toggles back to the original value
        d0 = done_cnt;
        pulse_req();
        tick(10);
        heating = 1'b0;
        tick(10);
        heating = 1'b1;
        tick(LEN + 30);
        check("net_unchanged_no_followup", done_cnt - d0, 1);

        // colour change mid-frame: one follow-up, back to back
        d0 = done_cnt;
        pulse_req();
        tick(10);
        colour = 3'b010;
        found  = 1'b0;
        for (int j = 0; j < LEN + 20 && !found; j++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1'b1;
        end
        check("first_done_seen", int'(found), 1);
        @(negedge clk);
        check("followup_busy", int'(busy), 1);
        check("followup_start_bit", int'(tx), 0);
        tick(LEN + 20);
        check("followup_count", done_cnt - d0, 2);

        // reset in the middle of DATA
        pulse_req();
        tick(20);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("retx_busy", int'(busy), 1);
        check("retx_start_bit", int'(tx), 0);
        tick(LEN + 10);
        check("retx_one_frame", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/home_status_tx.md
# home_status_tx

Serial status transmitter for the smart-home controller. It snapshots the climate, blinds, lights and temperature state into a 12-bit status word and sends it, LSB first, as an asynchronous frame to the wall-panel display. A frame starts automatically whenever the status differs from the last word sent, or on explicit request. This block is the outbound end of the panel link; the panel's receiver is the other end.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal values are 2 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- heating  in  1  heating-active status
- cooling  in  1  cooling-active status
- blinds  in  2  blinds position code
- colour  in  3  current light colour
- temperature  in  5  current temperature reading
- send_req  in  1  one-cycle request to force a frame; sampled only in IDLE
- tx  out  1  serial line; idles high
- busy  out  1  high from the first START cycle through the last STOP cycle
- done  out  1  one-cycle pulse on the final STOP cycle

## Operation
- Payload is {temperature[4:0], colour[2:0], blinds[1:0], cooling, heating}, 12 bits, bit 0 = heating.
- FSM states: IDLE, START, DATA, PARITY (only when configured in), STOP.
- IDLE → START when send_req = 1 or payload ≠ last_sent. In the same edge:
  - shift register ← payload
  - last_sent ← payload
  - bit counter ← 0
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift[0]. Every CLKS_PER_BIT cycles the register shifts right and the bit counter increments. After bit 11 completes, go to PARITY or STOP.
- PARITY: tx = even parity of the captured word, held for CLKS_PER_BIT cycles.
- STOP: tx = 1 for CLKS_PER_BIT cycles. done = 1 on the last STOP cycle. Then go to IDLE.
- Inputs that change mid-frame do not disturb the frame in flight. On return to IDLE the comparison against last_sent runs again, so a changed status goes out as the next frame. Intermediate values are dropped; only the latest status is sent.
- send_req during a frame is ignored and is not queued.
- If the status is unchanged and send_req is held high, back-to-back identical frames are sent.

## Timing
- Reset values: tx = 1, busy = 0, done = 0, state = IDLE, last_sent = 0, counters = 0.
- After reset is released, a nonzero payload starts a frame on the first clock edge.
- Trigger latency: trigger seen at edge k means START begins with tx = 0 and busy = 1 in cycle k+1.
- Frame length is 14·CLKS_PER_BIT cycles, or 15·CLKS_PER_BIT with parity. No idle gap is required between frames: the earliest next START is the cycle after done.
- Bit timing is a counter from 0 to CLKS_PER_BIT−1; bit boundaries occur when it wraps.
- rst asserted at any point aborts the frame. The next cycle shows the reset values, and no done pulse is produced.

## Configuration
- Macro: HOME_STATUS_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP, sending even parity over the 12 payload bits. Frame length is 15·CLKS_PER_BIT.
- Undefined: no PARITY state; DATA goes directly to STOP. Frame length is 14·CLKS_PER_BIT.

## Structure
- Package home_pkg holds:
  - PAYLOAD_W = 12
  - field offsets: HEAT_B = 0, COOL_B = 1, BLIND_LSB = 2, COLOUR_LSB = 4, TEMP_LSB = 7
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
- One sub-module, bit_timer, implements the CLKS_PER_BIT cycle counter. It has a clear input and a one-cycle bit_end output. The top level holds the FSM, shift register, bit counter and last_sent.

## Test plan
Benches use CLKS_PER_BIT = 4.
- Reset then inputs all zero → tx stays 1, busy stays 0 for 100 cycles; no frame is sent.
- temperature = 21, colour = 3'b100, blinds = 2'b01, cooling = 0, heating = 1 (payload 12'hAC5) → frame starts one cycle later. Line shows 0, then 1,0,1,0,0,0,1,1,0,1,0,1 (4 cycles each), then 1. done appears at cycle 56.
- Same payload with HOME_STATUS_TX_PARITY_EN defined → parity bit 0 after bit 11; done at cycle 60.
- Status unchanged, send_req pulsed in IDLE → identical frame resent. send_req pulsed mid-frame → no extra frame.
- heating toggles 1→0→1 during a frame (net unchanged) → no follow-up frame. colour changes to 3'b010 mid-frame → exactly one follow-up frame carrying the new colour, starting the cycle after done.
- rst asserted in the middle of DATA → next cycle tx = 1, busy = 0, no done. last_sent clears to 0, so a nonzero payload retransmits right after reset is released.
